// File: rtl/rst_req_if.sv
// rst_req_if -- request/status bundle for rst_req_gen.
//
// Signals:
//   PB_n        raw push-button, asynchronous, active-low
//   sw_rst_req  one-cycle software reset request
//   wdog_kick   watchdog service pulse (only meaningful with RST_REQ_WDOG_EN)
//   RST_n_out   active-low reset request towards the downstream synchronizer
//   busy        generator is not idle
//   cause       source of the last reset: 00 none, 01 button, 10 software, 11 watchdog
//
// Modports:
//   master  the request source and status consumer (board / testbench)
//   slave   the reset request generator
interface rst_req_if;
  logic       PB_n;
  logic       sw_rst_req;
  logic       wdog_kick;
  logic       RST_n_out;
  logic       busy;
  logic [1:0] cause;

  modport master (
    output PB_n, sw_rst_req, wdog_kick,
    input  RST_n_out, busy, cause
  );

  modport slave (
    input  PB_n, sw_rst_req, wdog_kick,
    output RST_n_out, busy, cause
  );
endinterface

// File: rtl/rst_req_gen.sv
// rst_req_gen -- debounced push-button / software / watchdog reset request
// generator producing a fixed-width, glitch-free active-low reset pulse.
//
// Ports:
//   clk   system clock, all flops rising-edge
//   rst   synchronous active-high block reset
//   bus   rst_req_if.slave: PB_n, sw_rst_req, wdog_kick in;
//         RST_n_out, busy, cause out
//
// Parameters:
//   DEB_CYCLES      cycles the synchronized button must stay low to count as a press
//   PULSE_CYCLES    width of the RST_n_out low pulse
//   HOLDOFF_CYCLES  lockout after the pulse before a new request is accepted
//   WDOG_CYCLES     watchdog timeout (only with RST_REQ_WDOG_EN)
//
// Build option:
//   RST_REQ_WDOG_EN  when defined, builds the watchdog; otherwise wdog_kick is
//                    ignored and cause never reports 11.
module rst_req_gen #(
  parameter int DEB_CYCLES     = 16,
  parameter int PULSE_CYCLES   = 8,
  parameter int HOLDOFF_CYCLES = 32,
  parameter int WDOG_CYCLES    = 1024
) (
  input logic    clk,
  input logic    rst,
  rst_req_if.slave bus
);

  localparam int MAX_AB  = (DEB_CYCLES > PULSE_CYCLES) ? DEB_CYCLES : PULSE_CYCLES;
  localparam int MAX_ALL = (MAX_AB > HOLDOFF_CYCLES) ? MAX_AB : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

  localparam logic [1:0] CAUSE_BUTTON = 2'b01;
  localparam logic [1:0] CAUSE_SW     = 2'b10;
  localparam logic [1:0] CAUSE_WDOG   = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ASSERT   = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       cause_reg, cause_next;
  logic             rst_n_out_reg;
  logic             pb_meta_reg, pb_sync_reg;
  logic             wdog_expire;

  // ---------------------------------------------------------------------------
  // Watchdog (optional)
  // ---------------------------------------------------------------------------
`ifdef RST_REQ_WDOG_EN
  localparam int              WD_W    = $clog2(WDOG_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_cnt_reg, wdog_cnt_next;

  // Expiry is judged on the registered count, so a kick arriving in the very
  // cycle the count reaches its limit is too late.
  assign wdog_expire = (wdog_cnt_reg == WD_LAST);

  always_comb begin
    wdog_cnt_next = '0;
    if (state_next == ASSERT && state_reg != ASSERT) begin
      wdog_cnt_next = '0;
    end else if (state_reg == IDLE || state_reg == DEBOUNCE) begin
      if (bus.wdog_kick) begin
        wdog_cnt_next = '0;
      end else if (wdog_cnt_reg < WD_LAST) begin
        wdog_cnt_next = wdog_cnt_reg + WD_W'(1);
      end else begin
        wdog_cnt_next = wdog_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
    end else begin
      wdog_cnt_reg <= wdog_cnt_next;
    end
  end
`else
  logic unused_wdog_kick;
  assign unused_wdog_kick = bus.wdog_kick;
  assign wdog_expire      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / counter / cause logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cause_next = cause_reg;

    case (state_reg)
      IDLE: begin
        if (wdog_expire) begin
          state_next = ASSERT;
          cnt_next   = '0;
          cause_next = CAUSE_WDOG;
        end else if (bus.sw_rst_req) begin
          state_next = ASSERT;
          cnt_next   = '0;
          cause_next = CAUSE_SW;
        end else if (!pb_sync_reg) begin
          state_next = DEBOUNCE;
          cnt_next   = '0;
        end
      end

      DEBOUNCE: begin
        // A software request is still honoured while a press is being
        // qualified; it simply pre-empts the button.
        if (wdog_expire) begin
          state_next = ASSERT;
          cnt_next   = '0;
          cause_next = CAUSE_WDOG;
        end else if (bus.sw_rst_req) begin
          state_next = ASSERT;
          cnt_next   = '0;
          cause_next = CAUSE_SW;
        end else if (pb_sync_reg) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = ASSERT;
          cnt_next   = '0;
          cause_next = CAUSE_BUTTON;
        end else if (cnt_reg < DEB_LAST) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ASSERT: begin
        if (cnt_reg == PULSE_LAST) begin
          state_next = HOLDOFF;
          cnt_next   = '0;
        end else if (cnt_reg < PULSE_LAST) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      HOLDOFF: begin
        // Counter saturates at the lockout limit; leaving also needs the
        // button released, which is what stops a held button retriggering.
        if (cnt_reg == HOLD_LAST) begin
          if (pb_sync_reg) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else if (cnt_reg < HOLD_LAST) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cause_reg     <= 2'b00;
      rst_n_out_reg <= 1'b1;
      pb_meta_reg   <= 1'b1;
      pb_sync_reg   <= 1'b1;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cause_reg     <= cause_next;
      // Registered from the next state so the pulse lines up exactly with
      // ASSERT occupancy and comes straight off a flop.
      rst_n_out_reg <= (state_next != ASSERT);
      pb_meta_reg   <= bus.PB_n;
      pb_sync_reg   <= pb_meta_reg;
    end
  end

  assign bus.RST_n_out = rst_n_out_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.cause     = cause_reg;

endmodule

// File: tb/tb_rst_req_gen.sv
// tb_rst_req_gen -- directed self-checking bench for rst_req_gen.
// Covers reset state, bounce rejection, clean press timing, software request,
// simultaneous request, mid-pulse reset, and the watchdog when
// RST_REQ_WDOG_EN is defined (absence of watchdog otherwise).
module tb_rst_req_gen;

  logic clk = 1'b0;
  logic rst;

  rst_req_if bus_if ();

  rst_req_gen #(
    .DEB_CYCLES    (16),
    .PULSE_CYCLES  (8),
    .HOLDOFF_CYCLES(32),
    .WDOG_CYCLES   (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int low_cnt   = 0;
  int kick_age  = 0;
  bit auto_kick = 1'b1;
  int base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; outputs are sampled 1 time unit after each rising edge.
  // With auto_kick set the watchdog is serviced every 21 cycles so that the
  // watchdog build can run the same directed sequence.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (auto_kick && kick_age >= 20) begin
        bus_if.wdog_kick = 1'b1;
        kick_age = 0;
      end else begin
        kick_age++;
      end
      @(posedge clk);
      #1;
      bus_if.wdog_kick = 1'b0;
      if (bus_if.RST_n_out === 1'b0) low_cnt++;
    end
  endtask

  task automatic sw_pulse();
    bus_if.sw_rst_req = 1'b1;
    run(1);
    bus_if.sw_rst_req = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.PB_n       = 1'b1;
    bus_if.sw_rst_req = 1'b0;
    bus_if.wdog_kick  = 1'b0;

    // Reset state
    run(3);
    check("reset_rst_n", 32'(bus_if.RST_n_out), 32'd1);
    check("reset_busy",  32'(bus_if.busy),      32'd0);
    check("reset_cause", 32'(bus_if.cause),     32'd0);
    rst = 1'b0;
    run(2);
    $display("TXN reset done rst_n=%0b busy=%0b cause=%0b", bus_if.RST_n_out, bus_if.busy, bus_if.cause);

    // Bounce: 5 low, 3 high, 5 low, released
    base = low_cnt;
    bus_if.PB_n = 1'b0; run(5);
    bus_if.PB_n = 1'b1; run(3);
    bus_if.PB_n = 1'b0; run(5);
    bus_if.PB_n = 1'b1; run(30);
    check("bounce_lows",  32'(low_cnt - base), 32'd0);
    check("bounce_cause", 32'(bus_if.cause),   32'd0);
    check("bounce_busy",  32'(bus_if.busy),    32'd0);
    $display("TXN bounce lows=%0d cause=%0b", low_cnt - base, bus_if.cause);

    // Clean press held 40 cycles: low from edge 19 through edge 26
    base = low_cnt;
    bus_if.PB_n = 1'b0;
    run(18);
    check("press_before_pulse", 32'(bus_if.RST_n_out), 32'd1);
    run(1);
    check("press_pulse_start",  32'(bus_if.RST_n_out), 32'd0);
    check("press_cause",        32'(bus_if.cause),     32'd1);
    run(7);
    check("press_pulse_last",   32'(bus_if.RST_n_out), 32'd0);
    run(1);
    check("press_pulse_end",    32'(bus_if.RST_n_out), 32'd1);
    check("press_busy_holdoff", 32'(bus_if.busy),      32'd1);
    run(13);
    bus_if.PB_n = 1'b1;
    run(60);
    check("press_lows",      32'(low_cnt - base), 32'd8);
    check("press_idle_busy", 32'(bus_if.busy),    32'd0);
    $display("TXN press lows=%0d cause=%0b", low_cnt - base, bus_if.cause);

    // Simultaneous: button reaches the FSM in the same cycle as sw_rst_req
    base = low_cnt;
    bus_if.PB_n = 1'b0;
    run(2);
    sw_pulse();
    check("simul_start", 32'(bus_if.RST_n_out), 32'd0);
    check("simul_cause", 32'(bus_if.cause),     32'd2);
    run(30);
    bus_if.PB_n = 1'b1;
    run(60);
    check("simul_lows",  32'(low_cnt - base), 32'd8);
    check("simul_busy",  32'(bus_if.busy),    32'd0);
    $display("TXN simultaneous lows=%0d cause=%0b", low_cnt - base, bus_if.cause);

    // Mid-pulse reset at cycle 3 of ASSERT
    sw_pulse();
    run(2);
    check("midrst_in_pulse", 32'(bus_if.RST_n_out), 32'd0);
    rst = 1'b1;
    run(1);
    check("midrst_rst_n", 32'(bus_if.RST_n_out), 32'd1);
    check("midrst_busy",  32'(bus_if.busy),      32'd0);
    check("midrst_cause", 32'(bus_if.cause),     32'd0);
    rst = 1'b0;
    run(2);
    $display("TXN mid-pulse reset rst_n=%0b busy=%0b cause=%0b", bus_if.RST_n_out, bus_if.busy, bus_if.cause);

    // Software request, second request during HOLDOFF ignored
    base = low_cnt;
    sw_pulse();
    check("sw_start", 32'(bus_if.RST_n_out), 32'd0);
    check("sw_cause", 32'(bus_if.cause),     32'd2);
    run(7);
    check("sw_last",  32'(bus_if.RST_n_out), 32'd0);
    run(1);
    check("sw_end",   32'(bus_if.RST_n_out), 32'd1);
    sw_pulse();
    check("sw_ignored_holdoff", 32'(bus_if.RST_n_out), 32'd1);
    run(40);
    check("sw_lows", 32'(low_cnt - base), 32'd8);
    check("sw_busy", 32'(bus_if.busy),    32'd0);
    $display("TXN software lows=%0d cause=%0b", low_cnt - base, bus_if.cause);

`ifdef RST_REQ_WDOG_EN
    // Kicking every 50 cycles keeps the watchdog quiet
    auto_kick = 1'b0;
    base = low_cnt;
    for (int k = 0; k < 4; k++) begin
      bus_if.wdog_kick = 1'b1;
      run(1);
      run(49);
    end
    check("wdog_kicked_lows", 32'(low_cnt - base), 32'd0);
    $display("TXN watchdog kicked lows=%0d", low_cnt - base);

    // Last kick, then expiry 64 cycles later
    bus_if.wdog_kick = 1'b1;
    run(1);
    run(63);
    check("wdog_before_expiry", 32'(bus_if.RST_n_out), 32'd1);
    run(1);
    check("wdog_pulse_start",   32'(bus_if.RST_n_out), 32'd0);
    check("wdog_cause",         32'(bus_if.cause),     32'd3);
    auto_kick = 1'b1;
    run(60);
    check("wdog_lows", 32'(low_cnt - base), 32'd8);
    $display("TXN watchdog expiry lows=%0d cause=%0b", low_cnt - base, bus_if.cause);
`else
    // No watchdog built: long idle without kicks never fires
    auto_kick = 1'b0;
    base = low_cnt;
    run(1200);
    check("nowdog_lows",  32'(low_cnt - base), 32'd0);
    check("nowdog_cause", 32'(bus_if.cause),   32'd2);
    $display("TXN no-watchdog idle lows=%0d cause=%0b", low_cnt - base, bus_if.cause);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rst_req_gen.md
RST_REQ_GEN -- requirements
Module: rst_req_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 16; cycles PB_n must read steadily low before it counts as a press.
REQ-002 Parameter PULSE_CYCLES, default 8; width of the RST_n_out low pulse, in clk cycles.
REQ-003 Parameter HOLDOFF_CYCLES, default 32; lockout after the pulse, during which no new request is accepted.
REQ-004 Parameter WDOG_CYCLES, default 1024; watchdog timeout in cycles (used only with WDOG_EN).
REQ-005 clk  input  1  system clock; all flops are rising-edge.
REQ-006 rst  input  1  synchronous, active-high block reset.
REQ-007 PB_n  input  1  raw push-button, asynchronous, active-low.
REQ-008 sw_rst_req  input  1  one-cycle software reset request.
REQ-009 wdog_kick  input  1  watchdog service pulse (used only with WDOG_EN).
REQ-010 RST_n_out  output  1  active-low reset request, driven to the downstream async reset synchronizer input.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 cause  output  2  source of the last reset: 00 none, 01 button, 10 software, 11 watchdog.

Function
REQ-013 PB_n SHALL pass through a 2-flop synchronizer before any use; the debounce logic uses only the synchronized value.
REQ-014 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, ASSERT, HOLDOFF.
REQ-015 IDLE: synchronized PB_n=0 -> DEBOUNCE, with the counter cleared.
REQ-016 IDLE: sw_rst_req=1 -> ASSERT next cycle, cause=10.
REQ-017 IDLE: if sw_rst_req and a button low both occur in the same cycle, sw_rst_req wins.
REQ-018 DEBOUNCE: synchronized PB_n=1 before the counter reaches DEB_CYCLES-1 -> IDLE; no pulse, cause unchanged.
REQ-019 DEBOUNCE: counter reaches DEB_CYCLES-1 with the input still low -> ASSERT, cause=01.
REQ-020 ASSERT: RST_n_out=0 for exactly PULSE_CYCLES consecutive cycles, then -> HOLDOFF.
REQ-021 HOLDOFF: RST_n_out=1; wait HOLDOFF_CYCLES cycles AND synchronized PB_n=1, then -> IDLE.
REQ-022 A button held down SHALL never retrigger.
REQ-023 sw_rst_req, PB_n and watchdog expiry SHALL be ignored in ASSERT and HOLDOFF; requests are not queued.
REQ-024 RST_n_out SHALL be driven directly from a flop, never glitching, and SHALL be low only in ASSERT.
REQ-025 Counters SHALL be sized to $clog2 of the largest parameter plus 1, SHALL saturate, and SHALL never wrap.
REQ-026 cause SHALL update on entry to ASSERT and hold until the next entry to ASSERT or rst.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, all counters 0, RST_n_out=1, busy=0 and cause=00.
REQ-028 rst asserted mid-ASSERT SHALL end the pulse: RST_n_out=1 on the edge after rst is sampled.
REQ-029 The synchronizer flops SHALL reset to 1 (button released).

Configuration
REQ-030 Macro RST_REQ_WDOG_EN SHALL control the watchdog.
- Defined: a WDOG_CYCLES counter runs in IDLE and DEBOUNCE, clears on wdog_kick, and on reaching WDOG_CYCLES-1 forces ASSERT with cause=11.
- Watchdog expiry has priority over sw_rst_req, which has priority over the button.
- The watchdog counter clears on entry to ASSERT.
REQ-031 Undefined: no watchdog logic is built, wdog_kick is ignored, and cause never equals 11.

Verification
REQ-032 Bounce: PB_n low 5 cycles, high, low 5 cycles (DEB_CYCLES=16) -> RST_n_out stays 1, cause=00.
REQ-033 Clean press: PB_n low 40 cycles -> RST_n_out low exactly 8 cycles starting at cycle 2+16+1, cause=01; no second pulse while held.
REQ-034 Software request: sw_rst_req pulse in IDLE -> RST_n_out low next cycle for 8 cycles, cause=10; a second sw_rst_req during HOLDOFF is ignored.
REQ-035 Simultaneous: sw_rst_req and button low in the same cycle -> cause=10, exactly one pulse.
REQ-036 Mid-pulse reset: rst raised at cycle 3 of ASSERT -> RST_n_out=1 the next cycle, busy=0, cause=00.
REQ-037 RST_REQ_WDOG_EN with WDOG_CYCLES=64:
- Kick every 50 cycles -> no pulse.
- Stop kicking -> pulse with cause=11 64 cycles after the last kick.
